// File: rtl/regfile_dump.sv
// Debug read-out engine: freezes the core, walks the register file read port and
// streams (address, data) pairs over valid/ready. Optional REGDUMP_SKIP_ZERO_EN drops zero-valued registers.
module regfile_dump #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  haltReq,
  input  logic                  haltAck,
  output logic [ADDR_WIDTH-1:0] rfAddr,
  input  logic [WIDTH-1:0]      rfData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [ADDR_WIDTH-1:0] outAddr,
  output logic [WIDTH-1:0]      outData,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] IDX_MAX = '1;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] w_idx_next;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [ADDR_WIDTH-1:0] w_out_addr_next;
  logic [WIDTH-1:0]      r_out_data;
  logic [WIDTH-1:0]      w_out_data_next;
  logic                  w_last;

  assign w_last = (r_idx == IDX_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_out_addr <= w_out_addr_next;
      r_out_data <= w_out_data_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_out_addr_next = r_out_addr;
    w_out_data_next = r_out_data;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_HALT;
          w_idx_next   = '0;
        end
      end
      S_HALT: begin
        if (haltAck) begin
          w_state_next = S_READ;
        end
      end
      S_READ: begin
`ifdef REGDUMP_SKIP_ZERO_EN
        // Zero registers are consumed in one cycle without producing an entry.
        if (rfData == '0) begin
          if (w_last) begin
            w_state_next = S_DONE;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end else begin
          w_out_addr_next = r_idx;
          w_out_data_next = rfData;
          w_state_next    = S_SEND;
        end
`else
        w_out_addr_next = r_idx;
        w_out_data_next = rfData;
        w_state_next    = S_SEND;
`endif
      end
      S_SEND: begin
        if (outReady) begin
          if (w_last) begin
            w_state_next = S_DONE;
          end else begin
            w_idx_next   = r_idx + 1'b1;
            w_state_next = S_READ;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign haltReq  = (r_state == S_HALT) || (r_state == S_READ) || (r_state == S_SEND);
  assign rfAddr   = r_idx;
  assign outValid = (r_state == S_SEND);
  assign outAddr  = r_out_addr;
  assign outData  = r_out_data;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized bench for regfile_dump: a register-file array feeds the read port and an
// expected-entry queue, built straight from the register contents, scores every accepted entry.
module tb_regfile_dump;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NREGS      = 1 << ADDR_WIDTH;
`ifdef REGDUMP_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic                  haltReq;
  logic                  haltAck;
  logic [ADDR_WIDTH-1:0] rfAddr;
  logic [WIDTH-1:0]      rfData;
  logic                  outValid;
  logic                  outReady;
  logic [ADDR_WIDTH-1:0] outAddr;
  logic [WIDTH-1:0]      outData;
  logic                  busy;
  logic                  done;

  logic [WIDTH-1:0] regs [NREGS];

  int errors = 0;
  int checks = 0;

  regfile_dump #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .haltReq(haltReq), .haltAck(haltAck),
    .rfAddr(rfAddr), .rfData(rfData), .outValid(outValid), .outReady(outReady),
    .outAddr(outAddr), .outData(outData), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb rfData = regs[rfAddr];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, ".haltReq"}, 64'(haltReq), 64'(0));
    check_val({tag, ".rfAddr"}, 64'(rfAddr), 64'(0));
    check_val({tag, ".outValid"}, 64'(outValid), 64'(0));
    check_val({tag, ".outAddr"}, 64'(outAddr), 64'(0));
    check_val({tag, ".outData"}, 64'(outData), 64'(0));
    check_val({tag, ".busy"}, 64'(busy), 64'(0));
    check_val({tag, ".done"}, 64'(done), 64'(0));
  endtask

  // One full dump; ready_pct is the chance outReady is offered per cycle.
  task automatic do_dump(input string name, input int ready_pct, input int ack_delay,
                         input bit restart_mid, input bit poke8);
    logic [ADDR_WIDTH-1:0] exp_a[$];
    logic [WIDTH-1:0]      exp_d[$];
    logic [ADDR_WIDTH-1:0] held_a;
    logic [WIDTH-1:0]      held_d;
    logic [ADDR_WIDTH-1:0] ea;
    logic [WIDTH-1:0]      ed;
    int exp_cyc = 1;
    int stall8  = 0;
    bit stalled = 1'b0;
    bit fin     = 1'b0;
    bit rdy;
    held_a = '0;
    held_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (SKIP_ZERO && regs[i] == '0) begin
        exp_cyc += 1;
      end else begin
        exp_a.push_back(ADDR_WIDTH'(i));
        exp_d.push_back(regs[i]);
        exp_cyc += 2;
      end
    end
    $display("%s: start, expecting %0d entries", name, exp_a.size());
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val({name, ".haltReq_on_start"}, 64'(haltReq), 64'(1));
    check_val({name, ".busy_on_start"}, 64'(busy), 64'(1));
    for (int k = 0; k < ack_delay; k++) begin
      start = (restart_mid && (k == ack_delay / 2));
      @(negedge clk);
      check_val({name, ".no_valid_before_ack"}, 64'(outValid), 64'(0));
      check_val({name, ".haltReq_wait"}, 64'(haltReq), 64'(1));
    end
    start   = 1'b0;
    haltAck = 1'b1;
    for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
      @(negedge clk);
      if (done) begin
        check_val({name, ".haltReq_in_done"}, 64'(haltReq), 64'(0));
        check_val({name, ".busy_in_done"}, 64'(busy), 64'(1));
        check_val({name, ".entries_left"}, 64'(exp_a.size()), 64'(0));
        if (ready_pct >= 100) begin
          check_val({name, ".ack_to_done_cycles"}, 64'(cyc), 64'(exp_cyc));
        end
        fin = 1'b1;
      end else begin
        check_val({name, ".haltReq_active"}, 64'(haltReq), 64'(1));
        if (stalled) begin
          check_val({name, ".hold_addr"}, 64'(outAddr), 64'(held_a));
          check_val({name, ".hold_data"}, 64'(outData), 64'(held_d));
        end
        if (outValid) begin
          check_val({name, ".rfAddr_tracks_idx"}, 64'(rfAddr), 64'(outAddr));
          rdy = (int'($urandom_range(99)) < ready_pct);
          if (poke8 && outAddr == 8 && stall8 < 3) begin
            rdy = 1'b0;
            regs[8] = 32'h0bad_f00d + 32'(stall8);
            stall8++;
          end
          outReady = rdy;
          if (rdy) begin
            stalled = 1'b0;
            if (exp_a.size() == 0) begin
              check_val({name, ".extra_entry"}, 64'(outAddr), 64'hffff);
            end else begin
              ea = exp_a.pop_front();
              ed = exp_d.pop_front();
              $display("%s: entry addr=%0d data=%08h (expected %0d %08h)", name, outAddr, outData, ea, ed);
              check_val({name, ".entry_addr"}, 64'(outAddr), 64'(ea));
              check_val({name, ".entry_data"}, 64'(outData), 64'(ed));
            end
          end else begin
            stalled = 1'b1;
            held_a  = outAddr;
            held_d  = outData;
          end
        end else begin
          stalled  = 1'b0;
          outReady = 1'($urandom_range(1));
        end
      end
    end
    if (!fin) begin
      check_val({name, ".timeout_no_done"}, 64'(0), 64'(1));
    end
    haltAck  = 1'b0;
    outReady = 1'b0;
    @(negedge clk);
    check_val({name, ".busy_after_done"}, 64'(busy), 64'(0));
    check_val({name, ".done_one_cycle"}, 64'(done), 64'(0));
    repeat (3) @(negedge clk);
    check_val({name, ".no_second_dump"}, 64'(busy), 64'(0));
  endtask

  initial begin
    bit found;
    reset    = 1'b1;
    start    = 1'b0;
    haltAck  = 1'b0;
    outReady = 1'b0;
    for (int i = 0; i < NREGS; i++) regs[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle("reset");

    for (int i = 0; i < NREGS; i++) regs[i] = 32'h1000_0000 + 32'(i);
    do_dump("ordered", 100, 3, 1'b0, 1'b0);

    for (int i = 0; i < NREGS; i++) regs[i] = $urandom | 32'h1;
    regs[8] = 32'hdeadbeef;
    do_dump("random_ready", 50, 4, 1'b0, 1'b1);

    for (int i = 0; i < NREGS; i++) regs[i] = $urandom | 32'h100;
    do_dump("start_while_busy", 50, 20, 1'b1, 1'b0);

    // Abandon a dump while entry 12 is waiting in SEND.
    for (int i = 0; i < NREGS; i++) regs[i] = 32'h2000_0000 + 32'(i);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    haltAck  = 1'b1;
    outReady = 1'b1;
    found    = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (outValid && outAddr == 12) found = 1'b1;
    end
    check_val("midreset.reached_idx12", 64'(found), 64'(1));
    outReady = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    haltAck = 1'b0;
    check_idle("midreset");
    do_dump("after_reset", 100, 3, 1'b0, 1'b0);

    for (int i = 0; i < NREGS; i++) regs[i] = '0;
    regs[0]  = 32'd5;
    regs[31] = 32'd7;
    do_dump("sparse", 100, 3, 1'b0, 1'b0);

    for (int i = 0; i < NREGS; i++) regs[i] = '0;
    do_dump("all_zero", 100, 3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
